cycle_timer: RTL and testbench
==============================

CYCLE_TIMER -- requirements
Module: cycle_timer

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 1000, meaning clk cycles per timer unit (>=1).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning width of the unit counter.
REQ-003 The block SHALL have parameters T1, T2, T3, defaults 10, 20, 30, meaning the durations in units for select codes 1, 2 and 3.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous and active-low.
REQ-006 timer_select  input  2  load strobe from the sequencing controller; 0 = no request, 1..3 = start duration T1..T3.
REQ-007 hold  input  1  when high, freezes the prescaler and the unit counter.
REQ-008 timer_elapsed  output  1  registered one-cycle pulse on expiry.
REQ-009 busy  output  1  registered; high while a duration is running.
REQ-010 remaining  output  CNT_W  registered count of units left.

Function
REQ-011 The block SHALL implement FSM states IDLE and RUN.
REQ-012 timer_select SHALL be sampled every rising edge and treated as a load strobe, not a level.
REQ-013 Load (timer_select!=0, any state): remaining<=T[sel], prescaler<=CLK_DIV-1, state<=RUN, busy<=1, timer_elapsed<=0.
REQ-014 A configured duration of 0 SHALL be loaded as 1.
REQ-015 In RUN with hold=0 and no load, the prescaler SHALL decrement each cycle.
REQ-016 When the prescaler is 0, it SHALL reload CLK_DIV-1 and remaining SHALL decrement by 1.
REQ-017 When remaining is 1 and the prescaler is 0 (expiry edge), the block SHALL set remaining<=0, state<=IDLE, busy<=0 and timer_elapsed<=1.
REQ-018 Latency: for a load at edge k, timer_elapsed SHALL be high during the cycle after edge k+T*CLK_DIV, for exactly one cycle.
REQ-019 timer_elapsed SHALL be 0 on every edge other than an expiry edge.
REQ-020 hold=1 SHALL freeze the prescaler and remaining, and SHALL add one cycle of latency per held RUN cycle.
REQ-021 A load SHALL take priority over hold.
REQ-022 Load in RUN SHALL restart with the new duration, with no elapsed pulse for the aborted run.
REQ-023 Load coinciding with an expiry edge SHALL win: restart with no elapsed pulse.
REQ-024 Load in the cycle timer_elapsed is high (the controller chaining the next phase) SHALL start normally.
REQ-025 In IDLE without a load, remaining, the prescaler and busy SHALL hold at 0.
REQ-026 remaining SHALL never wrap below 0.
REQ-027 T1..T3 SHALL be checked at elaboration to fit in CNT_W; the prescaler width SHALL be $clog2(CLK_DIV) with a minimum of 1.

Reset
REQ-028 rst low SHALL asynchronously force state=IDLE, timer_elapsed=0, busy=0, remaining=0 and prescaler=0.
REQ-029 Reset mid-RUN SHALL abort silently, with no elapsed pulse.
REQ-030 After reset deassertion, the block SHALL act on the first load at the next edge.

Structure
REQ-031 Package cycle_timer_pkg SHALL hold the select encodings (SEL_NONE=0, SEL_1=1, SEL_2=2, SEL_3=3) and the state type {IDLE, RUN}.
REQ-032 One sub-module, tick_gen, SHALL implement the loadable prescaler with a load/enable/hold interface and a one-cycle tick output.
REQ-033 The FSM and the unit counter SHALL live in cycle_timer.

Verification (CLK_DIV=4, T1=3, T2=2, T3=5)
REQ-034 Scenario: sel=1 for 1 cycle at edge 0 -> busy high from edge 0, remaining 3,2,1,0 at edges 4,8,12; elapsed high only in the cycle after edge 12.
REQ-035 Scenario: chain sel=1, then sel=2 in the elapsed cycle, then sel=3 -> elapsed pulses 12, 8 and 20 cycles after the respective loads; no gaps.
REQ-036 Scenario: sel=3 load, then sel=2 at edge 6 -> remaining=2 at edge 6, elapsed 8 cycles later, no pulse for the aborted run.
REQ-037 Scenario: sel=1 load with hold=1 for 5 cycles mid-run -> elapsed delayed to 17 cycles after load; remaining is stable during hold.
REQ-038 Scenario: rst low for 1 cycle at edge 7 of a T3 run -> all outputs 0 immediately, no elapsed ever; a subsequent sel=2 gives elapsed 8 cycles after the load.
REQ-039 Scenario: sel=2 asserted on the expiry edge of a T1 run -> no pulse at that edge; elapsed 8 cycles later.

Source files
------------

// File: rtl/cycle_timer_pkg.sv
// cycle_timer_pkg: select encodings and FSM state type for cycle_timer.
package cycle_timer_pkg;
    typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_1 = 2'd1, SEL_2 = 2'd2, SEL_3 = 2'd3} sel_t;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/cycle_timer_tick_gen.sv
// tick_gen: loadable down-counting prescaler, one-cycle tick each time it wraps.
module tick_gen #(
    parameter int CLK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    input  logic hold,
    output logic tick
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] RELOAD = PW'(CLK_DIV - 1);

    logic [PW-1:0] cnt;

    assign tick = en && !hold && (cnt == '0);

    // Load wins over hold; a disabled prescaler parks at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= RELOAD;
        else if (!en)
            cnt <= '0;
        else if (!hold)
            cnt <= (cnt == '0) ? RELOAD : cnt - 1'b1;
    end
endmodule

// File: rtl/cycle_timer.sv
// cycle_timer: strobe-loaded duration timer counting prescaled units,
// reporting busy, remaining units and a one-cycle elapsed pulse.
module cycle_timer
    import cycle_timer_pkg::*;
#(
    parameter int CLK_DIV = 1000,
    parameter int CNT_W   = 16,
    parameter int T1      = 10,
    parameter int T2      = 20,
    parameter int T3      = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       timer_select,
    input  logic             hold,
    output logic             timer_elapsed,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);
    if (CLK_DIV < 1) begin : g_bad_div
        $error("cycle_timer: CLK_DIV must be >= 1");
    end
    if (T1 < 0 || T2 < 0 || T3 < 0 || T1 >= (2 ** CNT_W) || T2 >= (2 ** CNT_W) || T3 >= (2 ** CNT_W)) begin : g_bad_t
        $error("cycle_timer: durations must fit in CNT_W");
    end

    // A zero-length duration still runs for one unit.
    localparam logic [CNT_W-1:0] D1 = (T1 == 0) ? CNT_W'(1) : CNT_W'(T1);
    localparam logic [CNT_W-1:0] D2 = (T2 == 0) ? CNT_W'(1) : CNT_W'(T2);
    localparam logic [CNT_W-1:0] D3 = (T3 == 0) ? CNT_W'(1) : CNT_W'(T3);

    state_t           state;
    logic             load;
    logic             tick;
    logic [CNT_W-1:0] dur;

    assign load = timer_select != SEL_NONE;
    assign dur  = (timer_select == SEL_1) ? D1 : (timer_select == SEL_2) ? D2 : D3;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .en   (state == RUN),
        .hold (hold),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            timer_elapsed <= 1'b0;
            busy          <= 1'b0;
            remaining     <= '0;
        end else begin
            timer_elapsed <= 1'b0;
            if (load) begin
                state     <= RUN;
                busy      <= 1'b1;
                remaining <= dur;
            end else if (state == RUN && tick) begin
                if (remaining <= CNT_W'(1)) begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    remaining     <= '0;
                    timer_elapsed <= 1'b1;
                end else begin
                    remaining <= remaining - 1'b1;
                end
            end else if (state == IDLE) begin
                busy      <= 1'b0;
                remaining <= '0;
            end
        end
    end
endmodule

// File: tb/tb_cycle_timer.sv
// tb_cycle_timer: directed scenarios for cycle_timer with CLK_DIV=4, T1=3, T2=2, T3=5.
module tb_cycle_timer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hold = 1'b0;
    logic [1:0] timer_select = 2'd0;
    logic       timer_elapsed;
    logic       busy;
    logic [7:0] remaining;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    cycle_timer #(.CLK_DIV(4), .CNT_W(8), .T1(3), .T2(2), .T3(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .timer_select  (timer_select),
        .hold          (hold),
        .timer_elapsed (timer_elapsed),
        .busy          (busy),
        .remaining     (remaining)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] s);
        timer_select = s;
        step();
        timer_select = 2'd0;
    endtask

    // Edges after the previous step until elapsed is seen; -1 if never.
    task automatic wait_pulse(output int n);
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (timer_elapsed) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({timer_elapsed, busy, remaining} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got el=%b busy=%b rem=%0d want 0 0 0", timer_elapsed, busy, remaining);
        end
        step();
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({timer_elapsed, busy, remaining} !== 10'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got el=%b busy=%b rem=%0d want 0 0 0", timer_elapsed, busy, remaining);
        end
    endtask

    task automatic test_basic();
        logic [7:0] er;
        load(2'd1);
        checks++;
        if (busy !== 1'b1 || remaining !== 8'd3 || timer_elapsed !== 1'b0) begin
            errors++;
            $display("FAIL basic_load: got busy=%b rem=%0d el=%b want 1 3 0", busy, remaining, timer_elapsed);
        end
        for (int i = 1; i <= 16; i++) begin
            step();
            er = (i < 4) ? 8'd3 : (i < 8) ? 8'd2 : (i < 12) ? 8'd1 : 8'd0;
            checks++;
            if (remaining !== er || timer_elapsed !== (i == 12) || busy !== (i < 12)) begin
                errors++;
                $display("FAIL basic_edge%0d: got rem=%0d el=%b busy=%b want %0d %b %b",
                         i, remaining, timer_elapsed, busy, er, i == 12, i < 12);
            end
        end
    endtask

    task automatic test_chain();
        int n;
        load(2'd1);
        wait_pulse(n);
        checks++;
        if (n !== 12) begin
            errors++;
            $display("FAIL chain_t1: got %0d want 12", n);
        end
        load(2'd2);
        checks++;
        if (busy !== 1'b1 || remaining !== 8'd2) begin
            errors++;
            $display("FAIL chain_load2: got busy=%b rem=%0d want 1 2", busy, remaining);
        end
        wait_pulse(n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL chain_t2: got %0d want 8", n);
        end
        load(2'd3);
        checks++;
        if (busy !== 1'b1 || remaining !== 8'd5) begin
            errors++;
            $display("FAIL chain_load3: got busy=%b rem=%0d want 1 5", busy, remaining);
        end
        wait_pulse(n);
        checks++;
        if (n !== 20) begin
            errors++;
            $display("FAIL chain_t3: got %0d want 20", n);
        end
        step();
    endtask

    task automatic test_restart();
        int n;
        int pulses;
        load(2'd3);
        pulses = 0;
        for (int i = 1; i <= 5; i++) begin
            step();
            pulses += int'(timer_elapsed);
        end
        load(2'd2);
        checks++;
        if (remaining !== 8'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_load: got rem=%0d busy=%b want 2 1", remaining, busy);
        end
        wait_pulse(n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL restart_latency: got %0d want 8", n);
        end
        for (int i = 1; i <= 20; i++) begin
            step();
            pulses += int'(timer_elapsed);
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL restart_extra_pulses: got %0d want 0", pulses);
        end
    endtask

    task automatic test_hold();
        int n;
        load(2'd1);
        for (int i = 1; i <= 5; i++) step();
        hold = 1'b1;
        for (int i = 6; i <= 10; i++) begin
            step();
            checks++;
            if (remaining !== 8'd2 || timer_elapsed !== 1'b0) begin
                errors++;
                $display("FAIL hold_edge%0d: got rem=%0d el=%b want 2 0", i, remaining, timer_elapsed);
            end
        end
        hold = 1'b0;
        wait_pulse(n);
        checks++;
        if (n !== 7) begin
            errors++;
            $display("FAIL hold_latency: got %0d want 17", n + 10);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int n;
        int pulses;
        load(2'd3);
        for (int i = 1; i <= 7; i++) step();
        rst = 1'b0;
        #1;
        checks++;
        if ({timer_elapsed, busy, remaining} !== 10'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got el=%b busy=%b rem=%0d want 0 0 0", timer_elapsed, busy, remaining);
        end
        step();
        rst = 1'b1;
        pulses = 0;
        for (int i = 1; i <= 25; i++) begin
            step();
            pulses += int'(timer_elapsed);
        end
        checks++;
        if (pulses !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_silent: got pulses=%0d busy=%b want 0 0", pulses, busy);
        end
        load(2'd2);
        wait_pulse(n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL midrst_reload: got %0d want 8", n);
        end
        step();
    endtask

    task automatic test_expiry_collision();
        int n;
        load(2'd1);
        for (int i = 1; i <= 11; i++) step();
        load(2'd2);
        checks++;
        if (timer_elapsed !== 1'b0 || remaining !== 8'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL collide_edge: got el=%b rem=%0d busy=%b want 0 2 1", timer_elapsed, remaining, busy);
        end
        wait_pulse(n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL collide_latency: got %0d want 8", n);
        end
        step();
        checks++;
        if (timer_elapsed !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL collide_single_pulse: got el=%b busy=%b want 0 0", timer_elapsed, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_chain();
        test_restart();
        test_hold();
        test_reset_mid();
        test_expiry_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
